// File: rtl/c_frag_cfg_loader.sv
// Byte-framed configuration loader for a column of C_FRAG logic muxes.
// A frame is checked against its XOR checksum before the shadow copy is made live.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | hunting for HDR_BYTE, any other accepted byte is dropped
// S_PAYLOAD | filling shadow, one byte per cell, cell 0 first
// S_CSUM    | waiting for the checksum byte
// S_COMMIT  | single cycle, shadow copied to CFG, input stalled
module c_frag_cfg_loader #(
  parameter int          NUM_CELLS = 4,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic                   QCK,
  input  logic                   QRN,
  input  logic [7:0]             DIN,
  input  logic                   DVALID,
  output logic                   DREADY,
  input  logic                   ABORT,
  output logic [8*NUM_CELLS-1:0] CFG,
  output logic                   CFG_OK,
  output logic                   DONE,
  output logic                   ERR,
  output logic                   BUSY
);

  localparam int IW = $clog2(NUM_CELLS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CSUM    = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [7:0]             csum;
  logic [8*NUM_CELLS-1:0] shadow;

  assign DREADY = (state != S_COMMIT);
  assign BUSY   = (state != S_IDLE);

  always_ff @(posedge QCK or negedge QRN) begin
    if (!QRN) begin
      state  <= S_IDLE;
      idx    <= '0;
      csum   <= '0;
      shadow <= '0;
      CFG    <= '0;
      CFG_OK <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      // COMMIT finishes even under ABORT; ABORT otherwise wins over a transfer
      if (state == S_COMMIT) begin
        CFG    <= shadow;
        CFG_OK <= 1'b1;
        DONE   <= 1'b1;
        state  <= S_IDLE;
      end else if (ABORT) begin
        state <= S_IDLE;
      end else if (DVALID) begin
        unique case (state)
          S_IDLE: begin
            if (DIN == HDR_BYTE) begin
              state <= S_PAYLOAD;
              idx   <= '0;
              csum  <= '0;
              ERR   <= 1'b0;
            end
          end
          S_PAYLOAD: begin
            shadow[int'(idx)*8 +: 8] <= DIN;
            csum <= csum ^ DIN;
            idx  <= idx + 1'b1;
            if (idx == LAST_IDX) state <= S_CSUM;
          end
          S_CSUM: begin
            if (DIN == csum) begin
              state <= S_COMMIT;
            end else begin
              state <= S_IDLE;
              ERR   <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_c_frag_cfg_loader.sv
// Directed bench for c_frag_cfg_loader (NUM_CELLS=2): frame-level queue model
// compared every cycle, plus literal checks on the documented scenarios.
module tb_c_frag_cfg_loader;

  localparam int         N   = 2;
  localparam logic [7:0] HDR = 8'hA5;

  logic             QCK = 1'b0;
  logic             QRN = 1'b0;
  logic [7:0]       din = 8'h00;
  logic             dv  = 1'b0;
  logic             ab  = 1'b0;
  logic             DREADY, CFG_OK, DONE, ERR, BUSY;
  logic [8*N-1:0]   CFG;

  int n_cmp = 0;
  int n_bad = 0;

  c_frag_cfg_loader #(.NUM_CELLS(N), .HDR_BYTE(HDR)) dut (
    .QCK(QCK), .QRN(QRN), .DIN(din), .DVALID(dv), .DREADY(DREADY), .ABORT(ab),
    .CFG(CFG), .CFG_OK(CFG_OK), .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 QCK = ~QCK;

  // Frame-level model: bytes collected after a header, verdict when the frame is complete
  logic [7:0]     frame_q[$];
  bit             in_frame, commit_pend;
  logic [8*N-1:0] pend_cfg, m_cfg;
  bit             m_ok, m_done, m_err;

  always @(posedge QCK or negedge QRN) begin
    if (!QRN) begin
      frame_q.delete();
      in_frame = 0; commit_pend = 0;
      pend_cfg = '0; m_cfg = '0; m_ok = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (commit_pend) begin
        m_cfg = pend_cfg; m_ok = 1; m_done = 1; commit_pend = 0;
      end else if (ab) begin
        in_frame = 0;
        frame_q.delete();
      end else if (dv) begin
        if (!in_frame) begin
          if (din == HDR) begin
            in_frame = 1;
            frame_q.delete();
            m_err = 0;
          end
        end else begin
          frame_q.push_back(din);
          if (frame_q.size() == N + 1) begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < N; i++) x = x ^ frame_q[i];
            if (x == frame_q[N]) begin
              for (int i = 0; i < N; i++) pend_cfg[8*i +: 8] = frame_q[i];
              commit_pend = 1;
            end else begin
              m_err = 1;
            end
            in_frame = 0;
            frame_q.delete();
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge QCK) begin
    if (QRN) begin
      cmp("cfg",    32'(CFG),    32'(m_cfg));
      cmp("cfg_ok", 32'(CFG_OK), 32'(m_ok));
      cmp("done",   32'(DONE),   32'(m_done));
      cmp("err",    32'(ERR),    32'(m_err));
      cmp("busy",   32'(BUSY),   32'(in_frame || commit_pend));
      cmp("dready", 32'(DREADY), 32'(!commit_pend));
    end
  end

  task automatic tick(input logic [7:0] d, input logic v, input logic a);
    @(negedge QCK);
    din = d; dv = v; ab = a;
  endtask

  task automatic send(input logic [7:0] b[]);
    foreach (b[i]) tick(b[i], 1'b1, 1'b0);
  endtask

  // one idle cycle, then sample just after the edge (the commit edge after a frame)
  task automatic after_edge();
    tick(8'h00, 1'b0, 1'b0);
    @(posedge QCK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge QCK);
    #2;
    cmp("rst_cfg",    32'(CFG),    32'h0);
    cmp("rst_ok",     32'(CFG_OK), 32'h0);
    cmp("rst_busy",   32'(BUSY),   32'h0);
    cmp("rst_dready", 32'(DREADY), 32'h1);
    QRN = 1'b1;

    // 1: good frame back-to-back
    send('{8'hA5, 8'h01, 8'h80, 8'h81});
    after_edge();
    cmp("t1_cfg",  32'(CFG),    32'h8001);
    cmp("t1_done", 32'(DONE),   32'h1);
    cmp("t1_ok",   32'(CFG_OK), 32'h1);
    cmp("t1_err",  32'(ERR),    32'h0);
    idle(2);

    // 2: bad checksum, then a zero frame clears ERR at its header
    send('{8'hA5, 8'h0F, 8'hF0, 8'h00});
    after_edge();
    cmp("t2_err",  32'(ERR),  32'h1);
    cmp("t2_cfg",  32'(CFG),  32'h8001);
    cmp("t2_done", 32'(DONE), 32'h0);
    tick(8'hA5, 1'b1, 1'b0);
    @(posedge QCK); #1;
    cmp("t2_errclr", 32'(ERR), 32'h0);
    send('{8'h00, 8'h00, 8'h00});
    after_edge();
    cmp("t2_cfg0", 32'(CFG), 32'h0);
    idle(2);

    // 3: leading garbage, header value as data
    send('{8'h12, 8'h34, 8'hA5, 8'hA5, 8'hA5, 8'h00});
    after_edge();
    cmp("t3_cfg", 32'(CFG), 32'hA5A5);
    idle(2);

    // 4: DVALID toggling through a frame
    send('{8'hA5});
    tick(8'hEE, 1'b0, 1'b0);
    send('{8'h3C});
    tick(8'hEE, 1'b0, 1'b0);
    send('{8'hC3});
    tick(8'hEE, 1'b0, 1'b0);
    send('{8'hFF});
    tick(8'hEE, 1'b0, 1'b0);
    cmp("t4_dready_commit", 32'(DREADY), 32'h0);
    @(posedge QCK); #1;
    cmp("t4_cfg", 32'(CFG), 32'hC33C);
    tick(8'hEE, 1'b1, 1'b0);
    idle(2);

    // 5: ABORT on the second payload byte, then a full frame
    send('{8'hA5, 8'h11});
    tick(8'h44, 1'b1, 1'b1);
    send('{8'hA5, 8'h11, 8'h22, 8'h33});
    after_edge();
    cmp("t5_cfg", 32'(CFG), 32'h2211);
    idle(2);

    // ABORT during COMMIT still commits
    send('{8'hA5, 8'h01, 8'h80, 8'h81});
    tick(8'h00, 1'b0, 1'b1);
    @(posedge QCK); #1;
    cmp("t7_cfg",  32'(CFG),  32'h8001);
    cmp("t7_done", 32'(DONE), 32'h1);
    idle(2);

    // 6: asynchronous reset mid-frame
    send('{8'hA5, 8'h01});
    @(posedge QCK); #2;
    QRN = 1'b0;
    #1;
    cmp("t6_cfg",  32'(CFG),    32'h0);
    cmp("t6_ok",   32'(CFG_OK), 32'h0);
    cmp("t6_busy", 32'(BUSY),   32'h0);
    dv = 1'b0;
    #1;
    QRN = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
